// File: rtl/ii_window_loader.sv
// ii_window_loader
// ----------------
// Front end of the Haar cascade evaluator. Takes one 20x20 window of pixels
// in raster order, writes its 21x21 integral image (row 0 / column 0 zero)
// straight into the cascade's integral-image RAM, computes the variance
// normalisation factor sqrt(N*sum(p^2) - (sum p)^2), starts the cascade and
// returns the cascade's accept/reject result upstream.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   win_start_i                  begin a new window (ignored while busy_o)
//   pix_data_i/pix_val_i/pix_ready_o   pixel stream, valid/ready handshake
//   ii_addr_wr_o/ii_data_wr_o/ii_val_wr_o   integral-image RAM write port
//   variance_norm_factor_o       floor(sqrt(nf)), or 1 when nf == 0
//   start_o / done_i / result_i  cascade handshake
//   busy_o, win_done_o, win_result_o   window status towards upstream
module ii_window_loader #(
  parameter int LENGHT_LINE_II = 21,
  parameter int ADDR_WIDTH_II  = $clog2(LENGHT_LINE_II*LENGHT_LINE_II),
  parameter int PIX_WIDTH      = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     win_start_i,
  input  logic [PIX_WIDTH-1:0]     pix_data_i,
  input  logic                     pix_val_i,
  output logic                     pix_ready_o,
  output logic [ADDR_WIDTH_II-1:0] ii_addr_wr_o,
  output logic [31:0]              ii_data_wr_o,
  output logic                     ii_val_wr_o,
  output logic [31:0]              variance_norm_factor_o,
  output logic                     start_o,
  input  logic                     done_i,
  input  logic                     result_i,
  output logic                     busy_o,
  output logic                     win_done_o,
  output logic                     win_result_o
);

  localparam int WIN    = LENGHT_LINE_II - 1;          // window side
  localparam int NPIX   = WIN * WIN;                   // pixels per window
  localparam int CW     = $clog2(LENGHT_LINE_II);      // x/y counter width
  localparam int SUM_W  = 17;
  localparam int SQ_W   = 25;
  localparam int ROW_W  = 13;
  localparam int II_W   = 17;
  localparam int NF_W   = 34;
  localparam int ROOT_W = NF_W / 2;
  localparam int REM_W  = ROOT_W + 1;
  localparam int BC_W   = $clog2(ROOT_W);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ZCOL, S_LOAD, S_NF, S_SQRT, S_START, S_WAIT
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            x_q, x_d, y_q, y_d;
  logic [SUM_W-1:0]         sum_q, sum_d;
  logic [SQ_W-1:0]          sqsum_q, sqsum_d;
  logic [ROW_W-1:0]         rowsum_q, rowsum_d;
  logic [II_W-1:0]          prev_q [LENGHT_LINE_II];
  logic [II_W-1:0]          prev_d [LENGHT_LINE_II];
  logic [NF_W-1:0]          rad_q, rad_d;
  logic [REM_W-1:0]         rem_q, rem_d;
  logic [ROOT_W-1:0]        root_q, root_d;
  logic [BC_W-1:0]          bit_cnt_q, bit_cnt_d;

  logic                     pix_ready_q, pix_ready_d;
  logic [ADDR_WIDTH_II-1:0] ii_addr_q, ii_addr_d;
  logic [31:0]              ii_data_q, ii_data_d;
  logic                     ii_val_q, ii_val_d;
  logic [31:0]              vnf_q, vnf_d;
  logic                     start_q, start_d;
  logic                     busy_q, busy_d;
  logic                     win_done_q, win_done_d;
  logic                     win_result_q, win_result_d;

  // Combinational helpers
  logic [ADDR_WIDTH_II-1:0] row_base;
  logic                     pix_fire;
  logic [ROW_W-1:0]         rowsum_new;
  logic [II_W-1:0]          ii_new;
  logic [REM_W+1:0]         rem_t;
  logic [REM_W+1:0]         trial;
  logic [ROOT_W-1:0]        root_new;

  assign row_base = ADDR_WIDTH_II'(y_q) * ADDR_WIDTH_II'(LENGHT_LINE_II);
  // pix_ready_q is high exactly in LOAD, so it doubles as the state qualifier.
  assign pix_fire = pix_val_i & pix_ready_q;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sum_d        = sum_q;
    sqsum_d      = sqsum_q;
    rowsum_d     = rowsum_q;
    prev_d       = prev_q;
    rad_d        = rad_q;
    rem_d        = rem_q;
    root_d       = root_q;
    bit_cnt_d    = bit_cnt_q;
    ii_addr_d    = ii_addr_q;
    ii_data_d    = ii_data_q;
    ii_val_d     = 1'b0;
    vnf_d        = vnf_q;
    busy_d       = busy_q;
    win_done_d   = 1'b0;
    win_result_d = win_result_q;
    rowsum_new   = '0;
    ii_new       = '0;
    rem_t        = '0;
    trial        = '0;
    root_new     = '0;

    // busy_o stays high through the win_done_o cycle, then drops.
    if (win_done_q) busy_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_start_i && !busy_q) begin
          sum_d        = '0;
          sqsum_d      = '0;
          rowsum_d     = '0;
          for (int i = 0; i < LENGHT_LINE_II; i++) prev_d[i] = '0;
          x_d          = '0;
          y_d          = '0;
          busy_d       = 1'b1;
          win_result_d = 1'b0;
          state_d      = S_CLEAR;
        end
      end

      S_CLEAR: begin
        // Row 0 of the integral image: x_q walks addresses 0..WIN.
        ii_val_d  = 1'b1;
        ii_addr_d = ADDR_WIDTH_II'(x_q);
        ii_data_d = '0;
        if (x_q == CW'(WIN)) begin
          y_d     = CW'(1);
          state_d = S_ZCOL;
        end else begin
          x_d = x_q + CW'(1);
        end
      end

      S_ZCOL: begin
        ii_val_d  = 1'b1;
        ii_addr_d = row_base;
        ii_data_d = '0;
        rowsum_d  = '0;
        x_d       = CW'(1);
        state_d   = S_LOAD;
      end

      S_LOAD: begin
        if (pix_fire) begin
          rowsum_new = rowsum_q + ROW_W'(pix_data_i);
          ii_new     = prev_q[x_q] + II_W'(rowsum_new);
          rowsum_d   = rowsum_new;
          prev_d[x_q] = ii_new;
          ii_val_d   = 1'b1;
          ii_addr_d  = row_base + ADDR_WIDTH_II'(x_q);
          ii_data_d  = 32'(ii_new);
          sum_d      = sum_q + SUM_W'(pix_data_i);
          sqsum_d    = sqsum_q + SQ_W'(pix_data_i) * SQ_W'(pix_data_i);
          if (x_q == CW'(WIN)) begin
            if (y_q == CW'(WIN)) begin
              state_d = S_NF;
            end else begin
              y_d     = y_q + CW'(1);
              state_d = S_ZCOL;
            end
          end else begin
            x_d = x_q + CW'(1);
          end
        end
      end

      S_NF: begin
        // Cauchy-Schwarz guarantees N*sum(p^2) >= (sum p)^2.
        rad_d     = NF_W'(sqsum_q) * NF_W'(NPIX) - NF_W'(sum_q) * NF_W'(sum_q);
        rem_d     = '0;
        root_d    = '0;
        bit_cnt_d = '0;
        state_d   = S_SQRT;
      end

      S_SQRT: begin
        // Restoring square root: bring down two radicand bits, try
        // subtracting 4*root+1, keep the result bit.
        rem_t = {rem_q, rad_q[NF_W-1 -: 2]};
        trial = {1'b0, root_q, 2'b01};
        if (rem_t >= trial) begin
          rem_d    = REM_W'(rem_t - trial);
          root_new = {root_q[ROOT_W-2:0], 1'b1};
        end else begin
          rem_d    = REM_W'(rem_t);
          root_new = {root_q[ROOT_W-2:0], 1'b0};
        end
        root_d    = root_new;
        rad_d     = {rad_q[NF_W-3:0], 2'b00};
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (bit_cnt_q == BC_W'(ROOT_W - 1)) begin
          // A zero root happens only for nf == 0 (flat window).
          vnf_d   = (root_new == '0) ? 32'd1 : 32'(root_new);
          state_d = S_START;
        end
      end

      S_START: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (done_i) begin
          win_result_d = result_i;
          win_done_d   = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered copies of state-derived strobes.
    pix_ready_d = (state_d == S_LOAD);
    start_d     = (state_d == S_START);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      sum_q        <= '0;
      sqsum_q      <= '0;
      rowsum_q     <= '0;
      for (int i = 0; i < LENGHT_LINE_II; i++) prev_q[i] <= '0;
      rad_q        <= '0;
      rem_q        <= '0;
      root_q       <= '0;
      bit_cnt_q    <= '0;
      pix_ready_q  <= 1'b0;
      ii_addr_q    <= '0;
      ii_data_q    <= '0;
      ii_val_q     <= 1'b0;
      vnf_q        <= 32'd1;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      win_done_q   <= 1'b0;
      win_result_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sum_q        <= sum_d;
      sqsum_q      <= sqsum_d;
      rowsum_q     <= rowsum_d;
      for (int i = 0; i < LENGHT_LINE_II; i++) prev_q[i] <= prev_d[i];
      rad_q        <= rad_d;
      rem_q        <= rem_d;
      root_q       <= root_d;
      bit_cnt_q    <= bit_cnt_d;
      pix_ready_q  <= pix_ready_d;
      ii_addr_q    <= ii_addr_d;
      ii_data_q    <= ii_data_d;
      ii_val_q     <= ii_val_d;
      vnf_q        <= vnf_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      win_done_q   <= win_done_d;
      win_result_q <= win_result_d;
    end
  end

  assign pix_ready_o            = pix_ready_q;
  assign ii_addr_wr_o           = ii_addr_q;
  assign ii_data_wr_o           = ii_data_q;
  assign ii_val_wr_o            = ii_val_q;
  assign variance_norm_factor_o = vnf_q;
  assign start_o                = start_q;
  assign busy_o                 = busy_q;
  assign win_done_o             = win_done_q;
  assign win_result_o           = win_result_q;

endmodule

// File: tb/tb_ii_window_loader.sv
// Directed bench for ii_window_loader: drives whole windows (zero, 255,
// checkerboard, random with gaps), a mid-window reset, and checks every
// integral-image write, the normalisation factor, latency and handshakes.
module tb_ii_window_loader;
  localparam int LEN = 21;
  localparam int AW  = $clog2(LEN*LEN);

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          win_start_i = 1'b0;
  logic [7:0]    pix_data_i = '0;
  logic          pix_val_i = 1'b0;
  logic          pix_ready_o;
  logic [AW-1:0] ii_addr_wr_o;
  logic [31:0]   ii_data_wr_o;
  logic          ii_val_wr_o;
  logic [31:0]   variance_norm_factor_o;
  logic          start_o;
  logic          done_i = 1'b0;
  logic          result_i = 1'b0;
  logic          busy_o;
  logic          win_done_o;
  logic          win_result_o;

  always #5 clk = ~clk;

  ii_window_loader dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .win_start_i            (win_start_i),
    .pix_data_i             (pix_data_i),
    .pix_val_i              (pix_val_i),
    .pix_ready_o            (pix_ready_o),
    .ii_addr_wr_o           (ii_addr_wr_o),
    .ii_data_wr_o           (ii_data_wr_o),
    .ii_val_wr_o            (ii_val_wr_o),
    .variance_norm_factor_o (variance_norm_factor_o),
    .start_o                (start_o),
    .done_i                 (done_i),
    .result_i               (result_i),
    .busy_o                 (busy_o),
    .win_done_o             (win_done_o),
    .win_result_o           (win_result_o)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  int unsigned pix [400];
  longint      ii_ref [LEN][LEN];
  logic [63:0] wr_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Capture every RAM write as {addr, data}.
  always @(negedge clk) begin
    if (!rst_i && ii_val_wr_o === 1'b1) wr_q.push_back(64'({ii_addr_wr_o, ii_data_wr_o}));
  end

  function automatic void fill(input int mode);
    for (int i = 0; i < 400; i++) begin
      case (mode)
        0: pix[i] = 0;
        1: pix[i] = 255;
        2: pix[i] = (((i / 20) + (i % 20)) % 2 == 1) ? 255 : 0;
        default: pix[i] = $urandom_range(0, 255);
      endcase
    end
  endfunction

  // Reference integral image by the 2-D recurrence.
  function automatic void build_ref();
    for (int y = 0; y < LEN; y++)
      for (int x = 0; x < LEN; x++)
        if (x == 0 || y == 0) ii_ref[y][x] = 0;
        else ii_ref[y][x] = pix[(y-1)*20 + (x-1)] + ii_ref[y-1][x] + ii_ref[y][x-1] - ii_ref[y-1][x-1];
  endfunction

  function automatic longint exp_factor();
    longint s = 0, q = 0, nf, lo, hi, mid;
    for (int i = 0; i < 400; i++) begin
      s += pix[i];
      q += pix[i] * pix[i];
    end
    nf = 400 * q - s * s;
    if (nf == 0) return 1;
    lo = 0; hi = 131071;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= nf) lo = mid; else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic check_writes(input string tag);
    int n;
    longint a, d;
    n = wr_q.size();
    check({tag, "_nwrites"}, n, 441);
    for (int i = 0; i < n && i < 441; i++) begin
      if (i < 21) begin
        a = i; d = 0;
      end else begin
        a = ((i - 21) / 21 + 1) * 21 + (i - 21) % 21;
        d = ii_ref[(i - 21) / 21 + 1][(i - 21) % 21];
      end
      check($sformatf("%s_wr%0d", tag, i), wr_q[i], 64'((a << 32) | d));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  pix_ready_o, 0);
    check({tag, "_val"},    ii_val_wr_o, 0);
    check({tag, "_addr"},   ii_addr_wr_o, 0);
    check({tag, "_data"},   ii_data_wr_o, 0);
    check({tag, "_vnf"},    variance_norm_factor_o, 1);
    check({tag, "_start"},  start_o, 0);
    check({tag, "_busy"},   busy_o, 0);
    check({tag, "_wdone"},  win_done_o, 0);
    check({tag, "_wres"},   win_result_o, 0);
  endtask

  // Runs one window end to end; cycle 1 is the win_start_i cycle.
  task automatic run_window(input string tag, input bit gaps, input bit res, input bit spurious);
    int cyc, idx, start_cyc, start_hits;
    bit acc, finished, spur_done;
    longint fexp;
    build_ref();
    fexp = exp_factor();
    wr_q.delete();
    idx = 0; acc = 0; start_cyc = 0; start_hits = 0; finished = 0; spur_done = 0;
    @(negedge clk);
    win_start_i = 1'b1; pix_val_i = 1'b0; cyc = 1;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      win_start_i = 1'b0; done_i = 1'b0; result_i = 1'b0;
      if (acc) idx++;
      if (start_o) begin
        start_hits++;
        if (start_cyc == 0) begin
          start_cyc = cyc;
          check({tag, "_vnf_at_start"}, variance_norm_factor_o, 64'(fexp));
        end
      end
      if (win_done_o) begin
        finished = 1;
        check({tag, "_done_lat"}, cyc, start_cyc + 21);
        check({tag, "_result"}, win_result_o, res);
        check({tag, "_busy_at_done"}, busy_o, 1);
        win_start_i = 1'b1;  // coincident with win_done_o: must be ignored
        pix_val_i = 1'b0; acc = 0;
      end else begin
        if (start_cyc != 0 && cyc == start_cyc + 20) begin
          done_i = 1'b1; result_i = res;
        end
        if (spurious && !spur_done && idx == 100) begin
          done_i = 1'b1; result_i = !res; spur_done = 1;
        end
        pix_val_i  = (idx < 400) && (gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
        pix_data_i = (idx < 400) ? 8'(pix[idx]) : 8'd0;
        acc = pix_val_i && pix_ready_o;
      end
    end
    check({tag, "_finished"}, finished, 1);
    check({tag, "_pix_used"}, idx, 400);
    check({tag, "_start_hits"}, start_hits, 1);
    if (!gaps) check({tag, "_start_lat"}, start_cyc, 461);
    @(negedge clk);
    win_start_i = 1'b0;
    check({tag, "_busy_after"}, busy_o, 0);
    check({tag, "_result_held"}, win_result_o, res);
    repeat (3) @(negedge clk);
    check({tag, "_vnf_held"}, variance_norm_factor_o, 64'(fexp));
    check_writes(tag);
    $display("window %s: writes=%0d factor=%0d start_cyc=%0d result=%0d",
             tag, wr_q.size(), variance_norm_factor_o, start_cyc, win_result_o);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_i = 1'b0;
    @(negedge clk);

    fill(0);
    run_window("zero", 0, 1, 0);
    check("zero_vnf", variance_norm_factor_o, 1);

    fill(1);
    run_window("all255", 0, 0, 1);
    check("all255_ii440", wr_q.size() > 440 ? wr_q[440] : 64'd0, 64'((64'd440 << 32) | 64'd102000));
    check("all255_vnf", variance_norm_factor_o, 1);

    fill(2);
    run_window("checker", 0, 1, 0);
    check("checker_vnf", variance_norm_factor_o, 51000);

    fill(3);
    run_window("rand_gaps", 1, 0, 0);

    // Reset around cycle 200 of LOAD (LOAD region starts at cycle 23).
    fill(3);
    wr_q.delete();
    @(negedge clk);
    win_start_i = 1'b1;
    @(negedge clk);
    win_start_i = 1'b0; pix_val_i = 1'b1; pix_data_i = 8'd7;
    repeat (220) @(negedge clk);
    check("midrst_busy_before", busy_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_i = 1'b0; pix_val_i = 1'b0;
    wr_q.delete();
    repeat (5) @(negedge clk);
    check("midrst_no_restart", wr_q.size(), 0);
    $display("reset mid-window: outputs returned to reset values");

    run_window("after_rst", 0, 1, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ii_window_loader.md
# ii_window_loader

Front-end of the Haar cascade evaluator. It accepts one 20×20 window of 8-bit pixels in raster order and builds its 21×21 integral image, with row 0 and column 0 zero, directly into the cascade's integral-image RAM write port. It also computes the window's variance normalisation factor, pulses the cascade start, and waits for the cascade's done. It then reports the accept/reject result for that window upstream.

## Interface
- LENGHT_LINE_II, 21, integral-image line length (window side + 1)
- ADDR_WIDTH_II, $clog2(LENGHT_LINE_II*LENGHT_LINE_II), integral-image RAM address width
- PIX_WIDTH, 8, pixel width

Ports:
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- win_start_i  in  1  pulse that begins a new window; ignored while busy_o=1
- pix_data_i  in  PIX_WIDTH  pixel value
- pix_val_i  in  1  pixel valid
- pix_ready_o  out  1  pixel accepted when pix_val_i & pix_ready_o
- ii_addr_wr_o  out  ADDR_WIDTH_II  integral-image write address, y*LENGHT_LINE_II+x
- ii_data_wr_o  out  32  integral-image value
- ii_val_wr_o  out  1  write enable
- variance_norm_factor_o  out  32  normalisation factor, zero-extended
- start_o  out  1  one-cycle cascade start
- done_i  in  1  cascade done pulse
- result_i  in  1  cascade result, valid with done_i
- busy_o  out  1  high from accepted win_start_i until win_done_o
- win_done_o  out  1  one-cycle window-complete pulse
- win_result_o  out  1  captured result_i; held until the next accepted win_start_i

## Operation
States: IDLE → CLEAR → ZCOL → LOAD → NF → SQRT → START → WAIT → IDLE.
- IDLE:
  - win_start_i clears sum, sqsum, rowsum, the 21-entry previous-row buffer and the x/y counters.
  - Go to CLEAR.
- CLEAR: writes 0 to addresses 0..20, one per cycle (21 cycles), y:=1, then ZCOL.
- ZCOL: writes 0 to address y*21, rowsum:=0, x:=1, then LOAD.
- LOAD:
  - pix_ready_o=1.
  - Each accepted pixel p: rowsum+=p; ii=prev[x]+rowsum; write ii at y*21+x; prev[x]:=ii; sum+=p; sqsum+=p*p; x++.
  - After x=20: if y=20 go to NF, else y++ and go to ZCOL.
- NF: nf = 400*sqsum − sum*sum, unsigned 34-bit; never negative by construction.
- SQRT:
  - Restoring bit-serial floor square root of nf, one result bit per cycle, 17 cycles, 17-bit root.
  - variance_norm_factor_o := (nf==0) ? 1 : root.
- START: start_o=1 for one cycle, then WAIT.
- WAIT:
  - On done_i, capture result_i into win_result_o, pulse win_done_o, go to IDLE.
  - done_i in any other state is ignored.
- Widths: sum 17 bits (max 102000), sqsum 25 bits (max 26,010,000), rowsum 13 bits, ii ≤ 102000 zero-extended to 32 bits.

## Timing
- Reset values:
  - State IDLE.
  - pix_ready_o, ii_val_wr_o, start_o, busy_o, win_done_o, win_result_o = 0.
  - ii_addr_wr_o, ii_data_wr_o = 0.
  - variance_norm_factor_o = 1.
- Reset mid-window aborts immediately; the next window needs a new win_start_i.
- Write outputs are registered: a pixel accepted in cycle t is written (ii_val_wr_o=1) in cycle t+1.
  - CLEAR/ZCOL writes likewise appear one cycle after the state cycle.
- pix_ready_o is 0 in ZCOL (one bubble per row); pixels offered then are not consumed.
- Minimum latency from win_start_i to start_o, with pix_val_i held high:
  - 1 (IDLE) + 21 (CLEAR) + 20×21 (ZCOL+LOAD) + 1 (NF) + 17 (SQRT) + 1 = 461 cycles.
- The last integral-image write and variance_norm_factor_o are both stable before start_o is high.
- variance_norm_factor_o is held until the next window's SQRT completes.
- pix_val_i low stalls LOAD with no state change; x/y are not advanced.
- win_start_i coincident with win_done_o is ignored (busy_o still 1 that cycle).

## Test plan
- All-zero window:
  - 441 writes of value 0.
  - variance_norm_factor_o=1; start_o 461 cycles after win_start_i.
- All-255 window:
  - ii at address y*21+x = 255*x*y; address 440 = 102000.
  - nf=0 → factor 1.
- Checkerboard ((x+y) odd = 255, else 0):
  - sum=51000, sqsum=13,005,000, nf=2,601,000,000.
  - variance_norm_factor_o=51000.
- Backpressure: pix_val_i toggled randomly at 50% → identical write sequence as with no gaps.
  - No pixel consumed in ZCOL cycles.
- Cascade handshake:
  - done_i=1, result_i=1 20 cycles after start_o → win_done_o one cycle later; win_result_o=1; busy_o falls.
  - Spurious done_i during LOAD is ignored.
- Reset on cycle 200 of LOAD:
  - All outputs return to reset values next cycle.
  - A fresh window then completes correctly.
